// File: rtl/tsp_pkg.sv
// Shared types and helpers for the TSP annealing datapath.
// City words pack X in the low coordinate field and Y in the high field.
package tsp_pkg;

    localparam int COORD_W = 32;
    localparam int CITY_W  = 64;

    typedef enum logic [1:0] {
        TC_IDLE,
        TC_FETCH,
        TC_DRAIN,
        TC_FIN
    } tour_cost_state_t;

    function automatic logic [COORD_W-1:0] city_x(input logic [CITY_W-1:0] c);
        return COORD_W'(c);
    endfunction

    function automatic logic [COORD_W-1:0] city_y(input logic [CITY_W-1:0] c);
        return COORD_W'(c >> COORD_W);
    endfunction

endpackage

// File: rtl/tour_cost_acc.sv
// Tour-length accumulator with synchronous clear and add-enable.
// TOUR_COST_SAT_EN selects clamping at all-ones with a sticky overflow flag; otherwise wraps.
module tour_cost_acc #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_add_en,
    input  logic [ACC_W-1:0] i_add,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_overflow
);

    logic [ACC_W-1:0] r_sum;

`ifdef TOUR_COST_SAT_EN
    logic             r_ovf;
    logic [ACC_W:0]   w_sum_ext;

    assign w_sum_ext = {1'b0, r_sum} + {1'b0, i_add};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (i_add_en) begin
            if (w_sum_ext[ACC_W]) begin
                r_sum <= '1;
                r_ovf <= 1'b1;
            end else begin
                r_sum <= w_sum_ext[ACC_W-1:0];
            end
        end
    end

    assign o_overflow = r_ovf;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add_en) begin
            r_sum <= r_sum + i_add;
        end
    end

    assign o_overflow = 1'b0;
`endif

    assign o_sum = r_sum;

endmodule

// File: rtl/tour_cost.sv
// Closed-tour length: fetches tour cities, streams city pairs to `distance`, sums results.
// Optional TOUR_COST_SAT_EN makes the accumulator saturate (see tour_cost_acc).
module tour_cost
    import tsp_pkg::*;
#(
    parameter int IDX_W    = 10,
    parameter int ACC_W    = 32,
    parameter int DIST_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W:0]    n_cities,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  total,
    output logic              overflow,
    output logic [IDX_W-1:0]  tour_addr,
    input  logic [IDX_W-1:0]  tour_rdata,
    output logic [IDX_W-1:0]  city_addr,
    input  logic [CITY_W-1:0] city_rdata,
    output logic [CITY_W-1:0] dist_citya,
    output logic [CITY_W-1:0] dist_cityb,
    output logic              dist_valid,
    input  logic              dist_out_valid,
    input  logic [31:0]       dist_out
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] N_MAX = {1'b1, {IDX_W{1'b0}}};

    tour_cost_state_t  r_state, w_state_nxt;

    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_acnt;
    logic [CNT_W-1:0]  r_k;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_rcv;
    logic [IDX_W-1:0]  r_tour_addr;
    logic              r_av;
    logic              r_tv;
    logic              r_cv;
    logic              r_close;
    logic [CITY_W-1:0] r_first;
    logic [CITY_W-1:0] r_prev;

    logic [CNT_W-1:0]  w_n_in;
    logic              w_start_ok;
    logic              w_degen;
    logic              w_issue_mid;
    logic              w_issue;
    logic              w_accept;
    logic              w_last_rcv;

    assign w_n_in      = (n_cities > N_MAX) ? N_MAX : n_cities;
    assign w_start_ok  = (r_state == TC_IDLE) && start;
    assign w_degen     = (w_n_in < CNT_W'(2));
    assign w_issue_mid = r_cv && (r_k != '0);
    assign w_issue     = w_issue_mid || r_close;

    // Only results backed by an outstanding issued pair are taken, so stale
    // results still draining from `distance` after a reset are dropped.
    assign w_accept    = dist_out_valid && (r_issued != r_rcv) &&
                         ((r_state == TC_FETCH) || (r_state == TC_DRAIN));
    assign w_last_rcv  = w_accept && (r_rcv == r_n - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            TC_IDLE: begin
                if (start) begin
                    w_state_nxt = w_degen ? TC_FIN : TC_FETCH;
                end
            end
            TC_FETCH: begin
                busy = 1'b1;
                if (r_close) begin
                    w_state_nxt = TC_DRAIN;
                end
            end
            TC_DRAIN: begin
                busy = 1'b1;
                if (w_last_rcv) begin
                    w_state_nxt = TC_FIN;
                end
            end
            TC_FIN: begin
                done        = 1'b1;
                w_state_nxt = TC_IDLE;
            end
            default: w_state_nxt = TC_IDLE;
        endcase
    end

    // Fetch pipeline: r_av = tour address valid, r_tv = tour data valid,
    // r_cv = city coordinate valid, each one cycle behind the previous.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n         <= '0;
            r_acnt      <= '0;
            r_tour_addr <= '0;
            r_av        <= 1'b0;
            r_tv        <= 1'b0;
            r_cv        <= 1'b0;
        end else begin
            r_tv <= r_av;
            r_cv <= r_tv;
            if (w_start_ok) begin
                r_n <= w_n_in;
                if (!w_degen) begin
                    r_tour_addr <= '0;
                    r_acnt      <= CNT_W'(1);
                    r_av        <= 1'b1;
                end
            end else if (r_av) begin
                if (r_acnt == r_n) begin
                    r_av <= 1'b0;
                end else begin
                    r_tour_addr <= r_tour_addr + 1'b1;
                    r_acnt      <= r_acnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k      <= '0;
            r_close  <= 1'b0;
            r_first  <= '0;
            r_prev   <= '0;
            r_issued <= '0;
            r_rcv    <= '0;
        end else begin
            r_close <= r_cv && (r_k == r_n - 1'b1);
            if (w_start_ok) begin
                r_k      <= '0;
                r_issued <= '0;
                r_rcv    <= '0;
            end else begin
                if (r_cv) begin
                    if (r_k == '0) begin
                        r_first <= city_rdata;
                    end
                    r_prev <= city_rdata;
                    r_k    <= r_k + 1'b1;
                end
                if (w_issue) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_accept) begin
                    r_rcv <= r_rcv + 1'b1;
                end
            end
        end
    end

    tour_cost_acc #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_start_ok),
        .i_add_en  (w_accept),
        .i_add     (ACC_W'(dist_out)),
        .o_sum     (total),
        .o_overflow(overflow)
    );

    assign tour_addr  = r_tour_addr;
    assign city_addr  = r_tv ? tour_rdata : '0;
    assign dist_valid = w_issue;
    assign dist_citya = w_issue ? r_prev : '0;
    assign dist_cityb = r_close ? r_first : (w_issue_mid ? city_rdata : '0);

    a_rcv_le_issued: assert property (@(posedge clk) disable iff (rst)
        r_rcv <= r_issued);

    a_result_latency: assert property (@(posedge clk) disable iff (rst)
        w_accept |-> $past(w_issue, DIST_LAT));

endmodule

// File: tb/tb_tour_cost.sv
// Directed bench for tour_cost: vector table plus reset-abort and ignored-start sequences.
module tb_tour_cost;
    import tsp_pkg::*;

    localparam int IDX_W = 4;
    localparam int ACC_W = 8;
    localparam int LAT   = 4;

`ifdef TOUR_COST_SAT_EN
    localparam int SAT_TOTAL = 255;
    localparam int SAT_OVF   = 1;
`else
    localparam int SAT_TOTAL = 44;
    localparam int SAT_OVF   = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [IDX_W:0]    n_cities = '0;
    logic              busy, done, overflow, dist_valid;
    logic [ACC_W-1:0]  total;
    logic [IDX_W-1:0]  tour_addr, city_addr;
    logic [IDX_W-1:0]  tour_rdata = '0;
    logic [CITY_W-1:0] city_rdata = '0;
    logic [CITY_W-1:0] dist_citya, dist_cityb;
    logic              dist_out_valid;
    logic [31:0]       dist_out;

    always #5 clk = ~clk;

    tour_cost #(
        .IDX_W   (IDX_W),
        .ACC_W   (ACC_W),
        .DIST_LAT(LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .n_cities      (n_cities),
        .busy          (busy),
        .done          (done),
        .total         (total),
        .overflow      (overflow),
        .tour_addr     (tour_addr),
        .tour_rdata    (tour_rdata),
        .city_addr     (city_addr),
        .city_rdata    (city_rdata),
        .dist_citya    (dist_citya),
        .dist_cityb    (dist_cityb),
        .dist_valid    (dist_valid),
        .dist_out_valid(dist_out_valid),
        .dist_out      (dist_out)
    );

    logic [IDX_W-1:0]  tour_mem [16];
    logic [CITY_W-1:0] city_mem [16];

    always @(posedge clk) begin
        tour_rdata <= tour_mem[tour_addr];
        city_rdata <= city_mem[city_addr];
    end

    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [31:0] euclid(input logic [CITY_W-1:0] a, input logic [CITY_W-1:0] b);
        longint unsigned ax = city_x(a), ay = city_y(a), bx = city_x(b), by = city_y(b);
        longint unsigned dx = (ax > bx) ? ax - bx : bx - ax;
        longint unsigned dy = (ay > by) ? ay - by : by - ay;
        return 32'(isqrt(dx * dx + dy * dy));
    endfunction

    // Reference `distance` unit: fixed latency, not reset by rst.
    bit          force_en = 1'b0;
    int          force_idx = 0;
    logic        pv [LAT] = '{default: 1'b0};
    logic [31:0] pd [LAT] = '{default: 32'd0};

    always @(posedge clk) begin : m_dist
        logic [31:0] v;
        v = '0;
        if (start) force_idx = 0;
        if (dist_valid) begin
            if (force_en) begin
                v = (force_idx == 0) ? 32'd200 : 32'd100;
                force_idx++;
            end else begin
                v = euclid(dist_citya, dist_cityb);
            end
        end
        pv[0] <= dist_valid;
        pd[0] <= v;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign dist_out_valid = pv[LAT-1];
    assign dist_out       = pd[LAT-1];

    // Run monitor, sampled on the falling edge; cycle 0 is the cycle start is driven.
    bit               mark = 1'b0;
    int               cyc, pairs, first_pair, last_pair, done_cnt, done_cyc, busy_cnt;
    bit               addr_moved;
    logic [IDX_W-1:0] ta0, ca0;

    always @(negedge clk) begin
        if (mark) begin
            cyc = 0; pairs = 0; first_pair = -1; last_pair = -1;
            done_cnt = 0; done_cyc = -1; busy_cnt = 0; addr_moved = 1'b0;
            ta0 = tour_addr; ca0 = city_addr;
        end else begin
            cyc++;
            if (dist_valid) begin
                if (pairs == 0) first_pair = cyc;
                last_pair = cyc;
                pairs++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (tour_addr != ta0 || city_addr != ca0) addr_moved = 1'b1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_tour(input int t0, input int t1, input int t2, input int t3);
        for (int i = 0; i < 16; i++) tour_mem[i] = IDX_W'(5);
        tour_mem[0] = IDX_W'(t0);
        tour_mem[1] = IDX_W'(t1);
        tour_mem[2] = IDX_W'(t2);
        tour_mem[3] = IDX_W'(t3);
    endtask

    task automatic start_run(input int n);
        @(posedge clk); #1;
        mark = 1'b1; n_cities = (IDX_W+1)'(n); start = 1'b1;
        @(posedge clk); #1;
        mark = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     busy,       0);
        check({tag, "_done"},     done,       0);
        check({tag, "_total"},    total,      0);
        check({tag, "_ovf"},      overflow,   0);
        check({tag, "_dvalid"},   dist_valid, 0);
        check({tag, "_taddr"},    tour_addr,  0);
        check({tag, "_caddr"},    city_addr,  0);
        check({tag, "_citya_z"},  (dist_citya == '0), 1);
        check({tag, "_cityb_z"},  (dist_cityb == '0), 1);
    endtask

    typedef struct {
        string name;
        int    n;
        int    t0, t1, t2, t3;
        bit    frc;
        int    exp_total, exp_ovf, exp_pairs, exp_first, exp_last, exp_done, exp_busy;
        bit    exp_moved;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;

        vecs[0] = '{"square",  4, 0, 1, 2, 3, 1'b0, 14,        0,       4, 4, 7,  12, 11, 1'b1};
        vecs[1] = '{"two",     2, 0, 4, 5, 5, 1'b0, 20,        0,       2, 4, 5,  10,  9, 1'b1};
        vecs[2] = '{"n1",      1, 0, 1, 2, 3, 1'b0, 0,         0,       0, -1, -1, 1,  0, 1'b0};
        vecs[3] = '{"n0",      0, 0, 1, 2, 3, 1'b0, 0,         0,       0, -1, -1, 1,  0, 1'b0};
        vecs[4] = '{"sat",     2, 0, 1, 5, 5, 1'b1, SAT_TOTAL, SAT_OVF, 2, 4, 5,  10,  9, 1'b1};
        vecs[5] = '{"clamp",  31, 0, 1, 2, 3, 1'b0, 14,        0,      16, 4, 19, 24, 23, 1'b1};

        for (int i = 0; i < 16; i++) city_mem[i] = '0;
        city_mem[1] = {32'd0, 32'd3};
        city_mem[2] = {32'd4, 32'd3};
        city_mem[3] = {32'd4, 32'd0};
        city_mem[4] = {32'd8, 32'd6};
        load_tour(0, 1, 2, 3);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load_tour(vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].t3);
            force_en = vecs[v].frc;
            start_run(vecs[v].n);
            wait_done(200, ok);
            check({vecs[v].name, "_finished"},  ok,         1);
            check({vecs[v].name, "_total"},     total,      vecs[v].exp_total);
            check({vecs[v].name, "_overflow"},  overflow,   vecs[v].exp_ovf);
            check({vecs[v].name, "_pairs"},     pairs,      vecs[v].exp_pairs);
            check({vecs[v].name, "_first_pair"}, first_pair, vecs[v].exp_first);
            check({vecs[v].name, "_last_pair"}, last_pair,  vecs[v].exp_last);
            check({vecs[v].name, "_done_cyc"},  done_cyc,   vecs[v].exp_done);
            check({vecs[v].name, "_done_cnt"},  done_cnt,   1);
            check({vecs[v].name, "_busy_cyc"},  busy_cnt,   vecs[v].exp_busy);
            check({vecs[v].name, "_addr_moved"}, addr_moved, vecs[v].exp_moved);
        end
        force_en = 1'b0;

        // Reset in cycle 5 of a square run, then an immediate restart.
        load_tour(0, 1, 2, 3);
        start_run(4);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("rstmid");
        check("rstmid_no_done", done_cnt, 0);
        start_run(4);
        wait_done(200, ok);
        check("rerun_finished", ok,       1);
        check("rerun_total",    total,    14);
        check("rerun_done_cnt", done_cnt, 1);
        check("rerun_done_cyc", done_cyc, 12);
        check("rerun_pairs",    pairs,    4);

        // Start pulsed mid-run must not disturb the run in progress.
        start_run(4);
        @(posedge clk); #1;
        n_cities = (IDX_W+1)'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, ok);
        check("ign_finished", ok,       1);
        check("ign_total",    total,    14);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_done_cyc", done_cyc, 12);
        check("ign_pairs",    pairs,    4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
